// File: rtl/mem_bus_pkg.sv
// Shared definitions for the data-memory bus controller: FSM state encoding,
// bus field widths and the default read word returned on a bus timeout.
package mem_bus_pkg;

  localparam int WADDR_W = 30;
  localparam int BE_W    = 4;

  localparam logic [BE_W-1:0] BE_ALL           = 4'hF;
  localparam logic [31:0]     ERR_WORD_DEFAULT = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB,
    ST_DRAIN,
    ST_RD,
    ST_RESP
  } bus_state_e;

endpackage

// File: rtl/dmem_bus_ctrl_wr_buf.sv
// One-entry posted write buffer: holds a single store (word address, data,
// byte lanes) from the moment it is accepted until the bus write retires it.
module wr_buf
  import mem_bus_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [WADDR_W-1:0] i_addr,
  input  logic [31:0]        i_wdata,
  input  logic [BE_W-1:0]    i_be,
  output logic               o_valid,
  output logic [WADDR_W-1:0] o_addr,
  output logic [31:0]        o_wdata,
  output logic [BE_W-1:0]    o_be
);

  logic               r_valid;
  logic [WADDR_W-1:0] r_addr;
  logic [31:0]        r_wdata;
  logic [BE_W-1:0]    r_be;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end
  end

  // NOTE: the payload has no reset; it is only ever observed while r_valid
  // is set, and r_valid is reset.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
      r_be    <= i_be;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;
  assign o_be    = r_be;

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller behind the M stage: posts stores into a one-entry
// buffer, serialises loads behind it, and times out a silent slave.
module dmem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TO_W     = 8,
  parameter logic [31:0] ERR_WORD = ERR_WORD_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_rd_M,
  input  logic               mem_wr_M,
  input  logic [31:0]        addr_M,
  input  logic [31:0]        wdata_M,
  input  logic [BE_W-1:0]    byte_en_M,
  output logic [31:0]        read_data_M,
  output logic               data_mem_ack,
  output logic               bus_req,
  output logic               bus_we,
  output logic [WADDR_W-1:0] bus_addr,
  output logic [31:0]        bus_wdata,
  output logic [BE_W-1:0]    bus_be,
  input  logic [31:0]        bus_rdata,
  input  logic               bus_ready,
  output logic               wb_busy,
  output logic               bus_err
);

  bus_state_e         r_state;
  logic               r_ack;
  logic               r_req;
  logic               r_we;
  logic               r_err;
  logic [WADDR_W-1:0] r_addr;
  logic [WADDR_W-1:0] r_rd_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic [BE_W-1:0]    r_be;
  logic [TO_W-1:0]    r_to_cnt;

  logic               w_buf_valid;
  logic               w_buf_load;
  logic               w_buf_clear;
  logic [WADDR_W-1:0] w_buf_addr;
  logic [31:0]        w_buf_wdata;
  logic [BE_W-1:0]    w_buf_be;
  logic               w_idle_sample;
  logic               w_timeout;
  logic               w_done;
  logic               w_txn_start;
  logic               w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^addr_M[1:0];

  // The request seen during an ack cycle is the one being acknowledged.
  assign w_idle_sample = (r_state == ST_IDLE) && !r_ack;
  assign w_timeout     = (r_to_cnt == TO_W'(TIMEOUT));
  assign w_done        = bus_ready || w_timeout;
  assign w_buf_load    = w_idle_sample && mem_wr_M && !mem_rd_M && !w_buf_valid;
  assign w_buf_clear   = ((r_state == ST_WB) || (r_state == ST_DRAIN)) && w_done;
  assign w_txn_start   = (w_idle_sample && (mem_rd_M || w_buf_valid)) ||
                         ((r_state == ST_DRAIN) && w_done);

  wr_buf u_wr_buf (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_addr  (addr_M[31:2]),
    .i_wdata (wdata_M),
    .i_be    (byte_en_M),
    .o_valid (w_buf_valid),
    .o_addr  (w_buf_addr),
    .o_wdata (w_buf_wdata),
    .o_be    (w_buf_be)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (w_txn_start) begin
      r_to_cnt <= '0;
    end else if (r_req && !bus_ready) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_ack     <= 1'b0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_rd_addr <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_be      <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_idle_sample) begin
            if (mem_rd_M) begin
              r_rd_addr <= addr_M[31:2];
              r_req     <= 1'b1;
              if (w_buf_valid) begin
                // A load never passes a buffered store: drain it first.
                r_state <= ST_DRAIN;
                r_we    <= 1'b1;
                r_addr  <= w_buf_addr;
                r_wdata <= w_buf_wdata;
                r_be    <= w_buf_be;
              end else begin
                r_state <= ST_RD;
                r_we    <= 1'b0;
                r_addr  <= addr_M[31:2];
                r_be    <= BE_ALL;
              end
            end else if (w_buf_load) begin
              r_ack <= 1'b1;
            end else if (w_buf_valid) begin
              r_state <= ST_WB;
              r_req   <= 1'b1;
              r_we    <= 1'b1;
              r_addr  <= w_buf_addr;
              r_wdata <= w_buf_wdata;
              r_be    <= w_buf_be;
            end
          end
        end
        ST_WB: begin
          if (w_done) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= !bus_ready;
          end
        end
        ST_DRAIN: begin
          if (w_done) begin
            // The held load follows back-to-back; bus_req stays high.
            r_state <= ST_RD;
            r_we    <= 1'b0;
            r_addr  <= r_rd_addr;
            r_be    <= BE_ALL;
            r_err   <= !bus_ready;
          end
        end
        ST_RD: begin
          if (w_done) begin
            r_state <= ST_RESP;
            r_req   <= 1'b0;
            r_ack   <= 1'b1;
            r_err   <= !bus_ready;
            r_rdata <= bus_ready ? bus_rdata : ERR_WORD;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign read_data_M  = r_rdata;
  assign data_mem_ack = r_ack;
  assign bus_req      = r_req;
  assign bus_we       = r_we;
  assign bus_addr     = r_addr;
  assign bus_wdata    = r_wdata;
  assign bus_be       = r_be;
  assign bus_err      = r_err;
  assign wb_busy      = w_buf_valid;

endmodule

// File: doc/dmem_bus_ctrl.md
Name: dmem_bus_ctrl

Overview:
- Data-memory bus controller downstream of the pipeline M stage.
- Consumes the M-stage address, store data and byte enables. Returns the raw read word and the `data_mem_ack` that the hazard unit uses to release the M-stage stall.
- Drives a single-master, word-addressed, ready-handshaked memory bus.
- Holds a one-entry posted write buffer, so stores retire in one cycle when the buffer is free.
- Has a bus timeout so a dead slave cannot hang the core.

Parameters:
- TIMEOUT, 255, max cycles `bus_req` stays high without `bus_ready` before forced termination.
- TO_W, 8, timeout counter width; must satisfy 2^TO_W > TIMEOUT.
- ERR_WORD, 32'hDEADBEEF, read data returned on timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mem_rd_M  in  1  load request, held until ack.
- mem_wr_M  in  1  store request, held until ack.
- addr_M  in  32  byte address from the M-stage ALU result; bits [1:0] ignored.
- wdata_M  in  32  store data, already lane-replicated.
- byte_en_M  in  4  store byte lanes.
- read_data_M  out  32  raw loaded word; sign extension is done downstream.
- data_mem_ack  out  1  one-cycle completion pulse.
- bus_req  out  1  transaction valid.
- bus_we  out  1  1 = write.
- bus_addr  out  30  word address.
- bus_wdata  out  32  write data.
- bus_be  out  4  byte enables; 4'hF for reads.
- bus_rdata  in  32  read data, valid with `bus_ready`.
- bus_ready  in  1  slave completes the current transaction this cycle.
- wb_busy  out  1  write buffer occupied.
- bus_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset: all outputs 0.
  - Write buffer invalid, FSM in IDLE, timeout counter 0.
  - Reset mid-transaction drops `bus_req` at the same edge; the buffered write is lost.
- All outputs are registered.
- Requests are sampled only in IDLE and only when `data_mem_ack` is 0. The request visible during the ack cycle is the one being acknowledged and is never re-accepted.
- `mem_rd_M` and `mem_wr_M` both high is illegal. The read wins and the write is ignored; the bench flags it.
- Store handling:
  - Store in IDLE with buffer empty: capture `{addr_M[31:2], wdata_M, byte_en_M}` into the buffer; `data_mem_ack` = 1 next cycle. Latency 1.
  - Store with buffer full: not accepted; retried each cycle until the buffer drains.
- FSM states:
  - IDLE: if a load is present, go to DRAIN when the buffer is valid, otherwise to RD. Else, if the buffer is valid, go to WB.
  - WB: `bus_req`=1, `bus_we`=1, drive the buffer contents. On `bus_ready`, clear the buffer and return to IDLE. On timeout, drop the write, pulse `bus_err`, return to IDLE.
  - DRAIN: same bus behaviour as WB. On completion or timeout, go to RD (the load is still held).
  - RD: `bus_req`=1, `bus_we`=0, `bus_be`=4'hF, `bus_addr`=`addr_M[31:2]` latched on entry. On `bus_ready`, latch `bus_rdata` into `read_data_M`. On timeout, latch ERR_WORD and pulse `bus_err`. Either way, go to RESP.
  - RESP: `data_mem_ack`=1 for exactly this cycle; go to IDLE.
- Ordering: a load never passes a buffered store. A load to the same word as the buffered store drains first; there is no forwarding.
- Load latency with a zero-wait slave: request seen at edge t, RD at t+1 (`bus_ready` high), RESP at t+2 → ack in cycle t+2. Add one bus transaction when draining.
- Bus rule: `bus_addr`, `bus_we`, `bus_wdata` and `bus_be` are stable while `bus_req` is high. `bus_req` drops the cycle after `bus_ready` is sampled, unless a new transaction follows immediately.
- Timeout counter:
  - Cleared on every transaction start.
  - Increments each cycle `bus_req`=1 and `bus_ready`=0.
  - Termination occurs at count == TIMEOUT; `bus_ready` in that same cycle takes priority (normal completion).
- A load withdrawn mid-transaction (pipeline flush) still completes on the bus and still pulses ack; the pipeline discards the data.
- `wb_busy` equals buffer valid.

Decomposition:
- Shared package `mem_bus_pkg`:
  - FSM state encoding (IDLE, WB, DRAIN, RD, RESP).
  - ERR_WORD default.
  - Bus width constants (30-bit word address, 4-bit byte enables).
- One natural sub-module: `wr_buf`, the one-entry write buffer with load / clear / valid.
- The timeout counter stays inline, using the existing `flip_flop_enable_clear` style primitives.

Test Plan:
- Zero-wait load: `addr_M`=32'h0000_1004, `bus_ready` tied 1, `bus_rdata`=32'h1234_5678 → `bus_addr`=30'h401, `read_data_M`=32'h1234_5678, one ack pulse 2 cycles after the request.
- Posted store then load: store `addr_M`=32'h100, `wdata_M`=32'hAABB_CCDD, `be`=4'h3 → ack after 1 cycle, `wb_busy`=1. The immediate load to 32'h100 shows a write (`bus_be`=4'h3) on the bus before the read; ack only after the read.
- Back-to-back stores with 3-wait slave → second store ack delayed until the first drains; exactly two bus writes, in order.
- Dead slave (`bus_ready`=0), load → `bus_err` pulses when the count reaches 255, `read_data_M`=32'hDEADBEEF, ack follows, FSM back in IDLE.
- `bus_ready` asserted in the timeout cycle → normal completion, no `bus_err`.
- Reset asserted during RD with 5-cycle wait → `bus_req`=0 at the next edge, `wb_busy`=0, no ack; a new load after reset completes normally.
